// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and the iteration-counter width helper.
package shift_add_mult_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // The counter must be able to hold WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl.sv
// Controller for the shift-add multiplier: IDLE/LOAD/RUN/DONE sequencing and
// the iteration counter. The datapath strobes are decoded straight from state.
module shift_add_mult_ctrl
  import shift_add_mult_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             last,
  output logic             load,
  output logic             step,
  output logic             finish,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       state
);

  logic [1:0] state_nxt;

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = start ? S_LOAD : S_IDLE;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   state_nxt = last ? S_DONE : S_RUN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_LOAD) begin
        cnt <= '0;
      end else if (state == S_RUN) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Strobes are one-hot by construction; any unexpected code looks like IDLE.
  always_comb begin
    load   = (state == S_LOAD);
    step   = (state == S_RUN);
    finish = (state == S_DONE);
    ready  = !(load || step || finish);
    busy   = load || step;
    done   = finish;
  end

endmodule

// File: rtl/shift_add_mult_seq.sv
// Sequential shift-add multiplier, one add+shift iteration per cycle.
// Optional signed mode is enabled by defining SHIFT_ADD_MULT_SIGNED_EN.
module shift_add_mult_seq
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SHIFT_ADD_MULT_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         state_dbg
);

  // Handshake: a request is accepted on a rising edge where ready=1 and
  // start=1; a/b (and is_signed) are captured on that edge only. done is a
  // one-cycle pulse, and product is loaded as that cycle ends and then held
  // until the next accepted request completes.

  logic             load;
  logic             step;
  logic             finish;
  logic             last;
  logic             capture;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] mreg;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   aext;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic             shift_in;
  logic             sgn;

  assign capture = ready && start;
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  shift_add_mult_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .last   (last),
    .load   (load),
    .step   (step),
    .finish (finish),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .cnt    (cnt),
    .state  (state_dbg)
  );

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic sreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= 1'b0;
    end else if (capture) begin
      sreg <= is_signed;
    end
  end

  assign sgn = sreg;
`else
  assign sgn = 1'b0;
`endif

  // Signed mode: the multiplier MSB carries weight -2^(WIDTH-1), so the last
  // partial product is subtracted and the accumulator shifts arithmetically.
  always_comb begin
    aext   = sgn ? {areg[WIDTH-1], areg} : {1'b0, areg};
    addend = '0;
    if (mreg[0]) begin
      addend = (sgn && last) ? -aext : aext;
    end
    sum      = acc + addend;
    shift_in = sgn ? sum[WIDTH] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      areg    <= '0;
      breg    <= '0;
      mreg    <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      if (capture) begin
        areg <= a;
        breg <= b;
      end
      if (load) begin
        acc  <= '0;
        mreg <= breg;
      end else if (step) begin
        acc  <= {shift_in, sum[WIDTH:1]};
        mreg <= {sum[0], mreg[WIDTH-1:1]};
      end
      if (finish) begin
        product <= {acc[WIDTH-1:0], mreg};
      end
    end
  end

endmodule

// File: doc/shift_add_mult_seq.md
Name: shift_add_mult_seq

Overview:
- Parametrised sequential shift-add multiplier: FSM controller plus datapath in one block.
- Successor to the fixed 4-state controller. Adds:
  - generic operand width
  - a one-iteration-per-cycle ADD/SHIFT merge
  - a start/ready/done handshake with an operand-capture guarantee
  - an optional signed mode
- Sits in the multiplier component directory; the ALU/top-level drives it.

Parameters:
- WIDTH, 8, operand width in bits (2..32); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while ready=1.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- ready  out  1  block idle, will accept start.
- busy  out  1  multiplication in progress.
- done  out  1  single-cycle pulse, product valid.
- product  out  2*WIDTH  result; held until next accepted start.

Behaviour:
- Reset (rst=0, async, any state including mid-operation):
  - state=IDLE, product=0, done=0, busy=0, ready=1, counter=0, internal registers=0.
  - A reset mid-operation aborts it; no done pulse follows.
- States: IDLE, LOAD, RUN, DONE. Encoding is 2 bits, shared via package.
- IDLE:
  - ready=1.
  - Next state is LOAD if start=1, else IDLE.
  - a and b are captured into internal regs on the edge that leaves IDLE.
  - Later changes to a/b do not affect the result.
- LOAD (1 cycle):
  - acc (WIDTH+1 bits) = 0; mreg = captured b; counter = 0.
  - busy=1. Next state is RUN.
  - Start held high is ignored; no re-trigger occurs, unlike the old START-wait behaviour.
- RUN (exactly WIDTH cycles):
  - Per cycle: sum = acc + (mreg[0] ? areg : 0), zero-extended to WIDTH+1.
  - {acc, mreg} <= {sum, mreg} >> 1, a logical right shift of the concatenation.
  - counter <= counter+1.
  - When counter == WIDTH-1 on the current cycle, next state is DONE. busy=1 throughout.
- DONE (1 cycle):
  - product <= {acc[WIDTH-1:0], mreg}. done=1, busy=0, ready=0.
  - Next state is IDLE.
  - Start asserted during DONE is ignored; it must be presented in IDLE.
- Latency: accepting edge to done pulse is WIDTH+2 cycles. Throughput is one product per WIDTH+3 cycles.
- product register updates only in DONE. It is stable at all other times, including during a following operation.
- Invariant: ready, busy and done are mutually exclusive (one-hot).
- Arithmetic: no overflow is possible. The unsigned result fits in 2*WIDTH bits exactly.
- Illegal state encoding: next state is IDLE, outputs as IDLE.

Optional Feature:
- Macro SHIFT_ADD_MULT_SIGNED_EN.
- Defined:
  - Adds input port is_signed (1 bit), captured with a/b.
  - When captured is_signed=1, operands are two's complement:
    - areg is sign-extended into the WIDTH+1-bit adder.
    - The shift is arithmetic, with acc MSB replicated.
    - On the final RUN iteration (counter==WIDTH-1), areg is subtracted instead of added when mreg[0]=1.
    - The product is the signed 2*WIDTH result.
  - When captured is_signed=0, behaviour is identical to the unsigned path.
- Undefined: no is_signed port; unsigned only. Timing and latency are identical in both builds.

Decomposition:
- Package shift_add_mult_pkg holds:
  - state localparams S_IDLE=2'd0, S_LOAD=2'd1, S_RUN=2'd2, S_DONE=2'd3
  - the CNT_W helper function
- Sub-module shift_add_mult_ctrl (FSM + counter):
  - Inputs: start, last-iteration flag.
  - Outputs: load, step, finish, ready, busy, done.
- The datapath (operand regs, adder, shift, product reg) stays in the top.

Test Plan:
- Reset mid-RUN: assert rst=0 during cycle 3 of RUN → ready=1, busy=0, done=0, product=0 immediately (async). No done pulse follows.
- WIDTH=8, a=8'd13, b=8'd11, pulse start:
  - done exactly 10 cycles after the accepting edge.
  - product=16'd143.
  - busy high for 9 cycles.
- WIDTH=8, a=8'hFF, b=8'hFF → product=16'hFE01. Also a=0, b=8'hA5 → product=0.
- Operand stability:
  - Change a/b every cycle after start is accepted → product reflects captured values, e.g. 3*5=15.
  - Holding start high continuously gives back-to-back operations separated by one IDLE cycle.
- Start during DONE/RUN ignored: pulse start in RUN and in DONE → exactly one done pulse; previous product is held until the new DONE.
- SHIFT_ADD_MULT_SIGNED_EN, WIDTH=8, is_signed=1:
  - a=-3 (8'hFD), b=7 → 16'hFFEB (-21).
  - a=-128, b=-128 → 16'h4000.
  - is_signed=0 with a=8'hFD, b=7 → 16'd1771.
